// File: rtl/vgm_wb_master_protocol_monitor.sv
// Passive Wishbone B4 master-side protocol monitor: sticky/pulsed violation flags and a transfer counter.
// Define VGM_WB_PIPELINED_EN for pipelined monitoring (adds STALL_I and MAX_OUTSTANDING).
//
// state    | meaning
// IDLE     | no transfer pending
// WAIT_ACK | strobe issued, waiting for ACK_I/ERR_I
module vgm_wb_master_protocol_monitor #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_WIDTH = DAT_WIDTH/8,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 16
`ifdef VGM_WB_PIPELINED_EN
  , parameter int MAX_OUTSTANDING = 4
`endif
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 CYC_O,
  input  logic                 STB_O,
  input  logic                 WE_O,
  input  logic [ADR_WIDTH-1:0] ADR_O,
  input  logic [DAT_WIDTH-1:0] DAT_O,
  input  logic [SEL_WIDTH-1:0] SEL_O,
  input  logic                 ACK_I,
  input  logic                 ERR_I,
`ifdef VGM_WB_PIPELINED_EN
  input  logic                 STALL_I,
`endif
  input  logic                 clr_i,
  output logic [5:0]           viol_o,
  output logic                 viol_pulse_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] xfer_cnt_o
);

  localparam logic [0:0]  IDLE     = 1'b0;
  localparam logic [0:0]  WAIT_ACK = 1'b1;
  localparam logic [15:0] TMO      = 16'(TIMEOUT);

  logic [0:0]           state_q, state_d;
  logic [15:0]          timer_q, timer_d;
  logic                 sh_we;
  logic [ADR_WIDTH-1:0] sh_adr;
  logic [DAT_WIDTH-1:0] sh_dat;
  logic [SEL_WIDTH-1:0] sh_sel;
  logic [5:0]           viol_q, viol_d, new_viol;
  logic                 pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0] xfer_q;
  logic                 capture, xfer_inc, strobe, ack_any, mismatch;

`ifdef VGM_WB_PIPELINED_EN
  localparam int            OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);
  logic [OW-1:0] outs_q, outs_d;
  logic          issue, held, held_q;
`endif

  always_comb begin
    strobe   = CYC_O & STB_O;
    ack_any  = ACK_I | ERR_I;
    // write data only has to hold on writes
    mismatch = (sh_we != WE_O) | (sh_adr != ADR_O) | (sh_sel != SEL_O) |
               (sh_we & (sh_dat != DAT_O));
    new_viol = '0;
    state_d  = state_q;
    timer_d  = timer_q;
    capture  = 1'b0;
    xfer_inc = 1'b0;
    new_viol[2] = STB_O & ~CYC_O;
    new_viol[5] = ACK_I & ERR_I;
`ifdef VGM_WB_PIPELINED_EN
    issue  = strobe & ~STALL_I;
    held   = strobe & STALL_I;
    outs_d = outs_q;
    new_viol[4] = ack_any & (outs_q == '0) & ~issue;
    if (held_q && held && mismatch) new_viol[0] = 1'b1;
    if (held_q && !STB_O) new_viol[1] = 1'b1;
    if (issue && outs_q == OMAX) new_viol[1] = 1'b1;
    capture  = held & ~held_q;
    xfer_inc = ack_any & ((outs_q != '0) | issue);
    if (!CYC_O) begin
      if (outs_q != '0) new_viol[1] = 1'b1;
      outs_d = '0;
    end else if (issue && !ack_any) begin
      if (outs_q != OMAX) outs_d = outs_q + OW'(1);
    end else if (ack_any && !issue && outs_q != '0) begin
      outs_d = outs_q - OW'(1);
    end
    if (outs_d == '0 || ack_any) timer_d = '0;
    else if (timer_q < TMO)      timer_d = timer_q + 16'd1;
    state_d = (outs_d != '0) ? WAIT_ACK : IDLE;
`else
    new_viol[4] = ack_any & ~strobe;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          if (ack_any) begin
            xfer_inc = 1'b1;
          end else begin
            capture = 1'b1;
            timer_d = 16'd1;
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (mismatch) new_viol[0] = 1'b1;
        if (!strobe) begin
          new_viol[1] = 1'b1;
          state_d     = IDLE;
          timer_d     = '0;
        end else if (ack_any) begin
          xfer_inc = 1'b1;
          state_d  = IDLE;
          timer_d  = '0;
        end else if (timer_q < TMO) begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
`endif
    // timeout fires once, on the transition onto the limit
    if (timer_d == TMO && timer_q != TMO) new_viol[3] = 1'b1;
    viol_d  = (clr_i ? 6'h00 : viol_q) | new_viol;
    pulse_d = |(new_viol & (clr_i ? 6'h3f : ~viol_q));
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      timer_q <= '0;
      sh_we   <= 1'b0;
      sh_adr  <= '0;
      sh_dat  <= '0;
      sh_sel  <= '0;
      viol_q  <= '0;
      pulse_q <= 1'b0;
      xfer_q  <= '0;
`ifdef VGM_WB_PIPELINED_EN
      outs_q  <= '0;
      held_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      viol_q  <= viol_d;
      pulse_q <= pulse_d;
      if (capture) begin
        sh_we  <= WE_O;
        sh_adr <= ADR_O;
        sh_dat <= DAT_O;
        sh_sel <= SEL_O;
      end
      if (xfer_inc && xfer_q != '1) xfer_q <= xfer_q + CNT_WIDTH'(1);
`ifdef VGM_WB_PIPELINED_EN
      outs_q <= outs_d;
      held_q <= held;
`endif
    end
  end

  assign viol_o       = viol_q;
  assign viol_pulse_o = pulse_q;
  assign busy_o       = (state_q == WAIT_ACK);
  assign xfer_cnt_o   = xfer_q;

endmodule

// File: tb/tb_vgm_wb_master_protocol_monitor.sv
// Vector/scoreboard bench for vgm_wb_master_protocol_monitor (TIMEOUT=4, plus a 2-bit counter copy).
module tb_vgm_wb_master_protocol_monitor;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        CYC_O, STB_O, WE_O, ACK_I, ERR_I, clr_i;
  logic [31:0] ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic [5:0]  viol_o, viol_s;
  logic        viol_pulse_o, pulse_s, busy_o, busy_s;
  logic [15:0] xfer_cnt_o;
  logic [1:0]  cnt_s;

  always #5 CLK_I = ~CLK_I;

  vgm_wb_master_protocol_monitor #(.ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT(4), .CNT_WIDTH(16)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .ACK_I(ACK_I), .ERR_I(ERR_I),
    .clr_i(clr_i), .viol_o(viol_o), .viol_pulse_o(viol_pulse_o), .busy_o(busy_o),
    .xfer_cnt_o(xfer_cnt_o));

  // same stimulus, 2-bit counter to exercise saturation
  vgm_wb_master_protocol_monitor #(.ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT(4), .CNT_WIDTH(2)) dut_s (
    .CLK_I(CLK_I), .RST_I(RST_I), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .ACK_I(ACK_I), .ERR_I(ERR_I),
    .clr_i(clr_i), .viol_o(viol_s), .viol_pulse_o(pulse_s), .busy_o(busy_s),
    .xfer_cnt_o(cnt_s));

  // ctl = {cyc, stb, we, ack, err, clr}; epb = {pulse, busy}
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [5:0]  ev;
    logic [1:0]  epb;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic [5:0] ctl, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [5:0] ev, input logic [1:0] epb, input logic [15:0] ec);
    vec_t v;
    v.ctl = ctl; v.adr = adr; v.dat = dat; v.ev = ev; v.epb = epb; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    logic [1:0] ecs;
    @(negedge CLK_I);
    {CYC_O, STB_O, WE_O, ACK_I, ERR_I, clr_i} = v.ctl;
    ADR_O = v.adr;
    DAT_O = v.dat;
    sb.push_back(v);
    @(posedge CLK_I);
    #1;
    e   = sb.pop_front();
    ecs = (e.ec > 16'd3) ? 2'd3 : e.ec[1:0];
    chk("viol",   idx, 32'(viol_o),       32'(e.ev));
    chk("pulse",  idx, 32'(viol_pulse_o), 32'(e.epb[1]));
    chk("busy",   idx, 32'(busy_o),       32'(e.epb[0]));
    chk("cnt",    idx, 32'(xfer_cnt_o),   32'(e.ec));
    chk("viol_s", idx, 32'(viol_s),       32'(e.ev));
    chk("pulse_s",idx, 32'(pulse_s),      32'(e.epb[1]));
    chk("busy_s", idx, 32'(busy_s),       32'(e.epb[0]));
    chk("cnt_s",  idx, 32'(cnt_s),        32'(ecs));
  endtask

  task automatic chk_zero(input int idx);
    chk("rst_viol",  idx, 32'(viol_o),       32'd0);
    chk("rst_pulse", idx, 32'(viol_pulse_o), 32'd0);
    chk("rst_busy",  idx, 32'(busy_o),       32'd0);
    chk("rst_cnt",   idx, 32'(xfer_cnt_o),   32'd0);
    chk("rst_viol_s",idx, 32'(viol_s),       32'd0);
    chk("rst_cnt_s", idx, 32'(cnt_s),        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_I = 1'b1;
    {CYC_O, STB_O, WE_O, ACK_I, ERR_I, clr_i} = 6'b0;
    ADR_O = '0; DAT_O = '0; SEL_O = 4'hF;

    // legal write, ack on the third waiting cycle
    for (int i = 0; i < 3; i++) tbl.push_back(mk(6'b111000, 32'h100, 32'hDEADBEEF, 6'h00, 2'b01, 16'd0));
    tbl.push_back(mk(6'b111100, 32'h100, 32'hDEADBEEF, 6'h00, 2'b00, 16'd1));
    tbl.push_back(mk(6'b000000, 32'h0,   32'h0,        6'h00, 2'b00, 16'd1));
    // read, address moves in waiting cycle 2, then acked
    tbl.push_back(mk(6'b110000, 32'h100, 32'h0, 6'h00, 2'b01, 16'd1));
    tbl.push_back(mk(6'b110000, 32'h100, 32'h0, 6'h00, 2'b01, 16'd1));
    tbl.push_back(mk(6'b110000, 32'h104, 32'h0, 6'h01, 2'b11, 16'd1));
    tbl.push_back(mk(6'b110100, 32'h104, 32'h0, 6'h01, 2'b00, 16'd2));
    tbl.push_back(mk(6'b000000, 32'h0,   32'h0, 6'h01, 2'b00, 16'd2));
    tbl.push_back(mk(6'b000001, 32'h0,   32'h0, 6'h00, 2'b00, 16'd2));
    // strobe dropped with no ack
    tbl.push_back(mk(6'b111000, 32'h200, 32'h11, 6'h00, 2'b01, 16'd2));
    tbl.push_back(mk(6'b111000, 32'h200, 32'h11, 6'h00, 2'b01, 16'd2));
    tbl.push_back(mk(6'b101000, 32'h200, 32'h11, 6'h02, 2'b10, 16'd2));
    tbl.push_back(mk(6'b000000, 32'h0,   32'h0,  6'h02, 2'b00, 16'd2));
    tbl.push_back(mk(6'b000001, 32'h0,   32'h0,  6'h00, 2'b00, 16'd2));
    // timeout after 4 cycles, single pulse, late ack still counts
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(6'b110000, 32'h300, 32'h0, (i >= 3) ? 6'h08 : 6'h00, {(i == 3), 1'b1}, 16'd2));
    tbl.push_back(mk(6'b110100, 32'h300, 32'h0, 6'h08, 2'b00, 16'd3));
    tbl.push_back(mk(6'b000001, 32'h0,   32'h0, 6'h00, 2'b00, 16'd3));
    // read data may change, write data may not
    tbl.push_back(mk(6'b110000, 32'h400, 32'h0,  6'h00, 2'b01, 16'd3));
    tbl.push_back(mk(6'b110000, 32'h400, 32'h55, 6'h00, 2'b01, 16'd3));
    tbl.push_back(mk(6'b110100, 32'h400, 32'h55, 6'h00, 2'b00, 16'd4));
    tbl.push_back(mk(6'b111000, 32'h500, 32'h1,  6'h00, 2'b01, 16'd4));
    tbl.push_back(mk(6'b111000, 32'h500, 32'h2,  6'h01, 2'b11, 16'd4));
    tbl.push_back(mk(6'b111100, 32'h500, 32'h2,  6'h01, 2'b00, 16'd5));
    tbl.push_back(mk(6'b000001, 32'h0,   32'h0,  6'h00, 2'b00, 16'd5));
    // STB without CYC, stray ack with clear, re-detect during clear
    tbl.push_back(mk(6'b010000, 32'h0, 32'h0, 6'h04, 2'b10, 16'd5));
    tbl.push_back(mk(6'b000101, 32'h0, 32'h0, 6'h10, 2'b10, 16'd5));
    tbl.push_back(mk(6'b000000, 32'h0, 32'h0, 6'h10, 2'b00, 16'd5));
    tbl.push_back(mk(6'b010000, 32'h0, 32'h0, 6'h14, 2'b10, 16'd5));
    tbl.push_back(mk(6'b010001, 32'h0, 32'h0, 6'h04, 2'b10, 16'd5));
    tbl.push_back(mk(6'b000001, 32'h0, 32'h0, 6'h00, 2'b00, 16'd5));
    // ACK+ERR zero-wait, plain zero-wait, multi-bit violations
    tbl.push_back(mk(6'b110110, 32'h600, 32'h0, 6'h20, 2'b10, 16'd6));
    tbl.push_back(mk(6'b110100, 32'h600, 32'h0, 6'h20, 2'b00, 16'd7));
    tbl.push_back(mk(6'b000110, 32'h0,   32'h0, 6'h30, 2'b10, 16'd7));
    tbl.push_back(mk(6'b000001, 32'h0,   32'h0, 6'h00, 2'b00, 16'd7));
    tbl.push_back(mk(6'b000110, 32'h0,   32'h0, 6'h30, 2'b10, 16'd7));
    tbl.push_back(mk(6'b000001, 32'h0,   32'h0, 6'h00, 2'b00, 16'd7));

    repeat (2) @(posedge CLK_I);
    #1;
    chk_zero(0);
    @(negedge CLK_I);
    RST_I = 1'b0;

    foreach (tbl[i]) step(tbl[i], i);

    // reset asserted between edges while waiting for an ack
    step(mk(6'b111000, 32'h700, 32'h1, 6'h00, 2'b01, 16'd7), 100);
    step(mk(6'b111000, 32'h704, 32'h1, 6'h01, 2'b11, 16'd7), 101);
    #2;
    RST_I = 1'b1;
    #1;
    chk_zero(1);
    @(negedge CLK_I);
    RST_I = 1'b0;
    {CYC_O, STB_O, WE_O, ACK_I, ERR_I, clr_i} = 6'b0;
    step(mk(6'b110000, 32'h800, 32'h0, 6'h00, 2'b01, 16'd0), 102);
    step(mk(6'b110100, 32'h800, 32'h0, 6'h00, 2'b00, 16'd1), 103);
    step(mk(6'b000000, 32'h0,   32'h0, 6'h00, 2'b00, 16'd1), 104);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vgm_wb_master_protocol_monitor.md
Name: vgm_wb_master_protocol_monitor

Overview:
- Synthesizable, parametrised Wishbone B4 master-side protocol monitor; successor to the assertion-only master checker.
- Sits passively on a master's outbound bus; tracks each bus cycle with an FSM and checks handshake and stability rules.
- Reports violations as sticky and pulsed flags, and counts completed transfers.
- Usable in simulation and on FPGA, where SVA is unavailable.

Parameters:
ADR_WIDTH, 32, width of ADR_O
DAT_WIDTH, 32, width of DAT_O; must be a multiple of 8
SEL_WIDTH, DAT_WIDTH/8, width of SEL_O
TIMEOUT, 16, max cycles from strobe to ACK_I/ERR_I before timeout flag; 1..65535
CNT_WIDTH, 16, width of transfer counter

Ports:
CLK_I  in  1  single clock, posedge
RST_I  in  1  reset, asynchronous, active-high
CYC_O  in  1  monitored master cycle
STB_O  in  1  monitored master strobe
WE_O  in  1  monitored write enable
ADR_O  in  ADR_WIDTH  monitored address
DAT_O  in  DAT_WIDTH  monitored write data
SEL_O  in  SEL_WIDTH  monitored byte selects
ACK_I  in  1  slave acknowledge
ERR_I  in  1  slave error
clr_i  in  1  clears sticky violation flags
viol_o  out  6  sticky flags: [0] ADR/DAT/WE/SEL changed before ack, [1] STB/CYC dropped before ack, [2] STB_O without CYC_O, [3] timeout, [4] ACK_I/ERR_I with no active strobe, [5] ACK_I and ERR_I together
viol_pulse_o  out  1  high one cycle when any new violation is detected
busy_o  out  1  high while in WAIT_ACK
xfer_cnt_o  out  CNT_WIDTH  completed transfers (ACK or ERR), saturating

Behaviour:
- Reset (async assert, sync release): state IDLE; viol_o=0; viol_pulse_o=0; busy_o=0; xfer_cnt_o=0; timer=0; shadow registers=0.
- All checks are sampled at posedge CLK_I. Flags are registered and visible the cycle after the offending cycle; viol_pulse_o has the same timing.
- IDLE:
  - CYC_O&&STB_O&&!ACK_I&&!ERR_I: capture {WE_O,ADR_O,DAT_O,SEL_O} into shadow, timer=1, go to WAIT_ACK.
  - CYC_O&&STB_O with ACK_I or ERR_I in the same cycle: zero-wait transfer; xfer_cnt_o+1; stay IDLE.
- WAIT_ACK:
  - Any of {WE_O,ADR_O,SEL_O} differs from shadow: set [0]. DAT_O differs and shadow WE=1: also set [0]. DAT_O is not checked on reads.
  - !STB_O or !CYC_O: set [1], go to IDLE, no count.
  - ACK_I or ERR_I with STB_O&&CYC_O: xfer_cnt_o+1, go to IDLE. Stability is checked in this cycle as well.
  - Otherwise timer+1, saturating at TIMEOUT. Set [3] once, on the cycle timer reaches TIMEOUT. Remain in WAIT_ACK.
- Any state:
  - STB_O&&!CYC_O: set [2].
  - (ACK_I||ERR_I)&&!(CYC_O&&STB_O): set [4].
  - ACK_I&&ERR_I: set [5]; counted as one transfer.
- Multiple violations in one cycle set all corresponding bits; viol_pulse_o=1 only if at least one bit was previously 0.
- clr_i clears viol_o next edge. A violation detected in the same cycle as clr_i wins: that bit stays set and viol_pulse_o fires.
- xfer_cnt_o saturates at all ones and never wraps.
- busy_o is a decode of state==WAIT_ACK.

Optional Feature:
- Macro VGM_WB_PIPELINED_EN.
- Defined:
  - Adds input STALL_I (1 bit) and parameter MAX_OUTSTANDING (default 4).
  - A transfer is issued on CYC_O&&STB_O&&!STALL_I.
  - An outstanding counter increments per issue and decrements per ACK_I/ERR_I; simultaneous issue and ack leaves it unchanged.
  - Shadow stability is checked only while STB_O&&STALL_I. Dropping STB_O while stalled sets [1].
  - ACK_I/ERR_I with outstanding==0 and no same-cycle issue sets [4]. CYC_O dropped with outstanding>0 sets [1] and zeroes the counter.
  - Timer runs while outstanding>0 and resets on each ack.
  - An issue when outstanding==MAX_OUTSTANDING sets [1].
- Not defined: classic single-outstanding behaviour as above; no STALL_I port.

Test Plan:
- Legal write, ADR=0x100, ack after 3 cycles, fields stable -> xfer_cnt_o=1, viol_o=0, busy_o high for 3 cycles.
- ADR_O changes 0x100->0x104 in WAIT_ACK cycle 2 -> viol_o=6'b000001, one viol_pulse_o; counted on later ack.
- STB_O deasserted after 2 cycles, no ack -> viol_o[1]=1, state IDLE, xfer_cnt_o unchanged.
- TIMEOUT=4, no ack for 10 cycles -> viol_o[3] set at cycle 4, single pulse; late ack then counts 1.
- ACK_I pulse with CYC_O=0, plus clr_i in the same cycle -> viol_o=6'b010000 after clear.
- RST_I asserted mid-WAIT_ACK, between clock edges -> all outputs 0 immediately; next legal transfer counts 1.
